// File: rtl/sram_pkg.sv
// Shared widths and controller state encoding for the SRAM write path.
package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sram_state_t;

endpackage

// File: rtl/sram_wr_fifo.sv
// Show-ahead word FIFO: the head entry is visible on rd_data while not empty.
// A push is taken when full provided a pop happens in the same cycle.
module sram_wr_fifo
  import sram_pkg::*;
#(
  parameter int WIDTH = SRAM_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  // Pointer update; the extra MSB separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sram_wr_sequencer.sv
// Packs an upstream byte stream into little-endian 32-bit words and writes
// them to consecutive SRAM word addresses through a small word FIFO.
//
//   state | meaning
//   IDLE  | waiting for start; zero-length request pulses done directly
//   RUN   | accepting bytes until 4*word_count have been taken
//   DRAIN | all bytes taken; emptying FIFO until the last word handshakes
module sram_wr_sequencer
  import sram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SRAM_ADDR_W-1:0] base_addr,
  input  logic [SRAM_ADDR_W-1:0] word_count,
  input  logic                   smp_valid,
  output logic                   smp_ready,
  input  logic [7:0]             smp_data,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [SRAM_ADDR_W-1:0] wr_addr,
  output logic [SRAM_DATA_W-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  sram_state_t            state_q, state_d;
  logic [1:0]             byte_cnt_q;
  logic [23:0]            pack_q;
  logic [SRAM_DATA_W-1:0] word_q;
  logic                   push_q;
  logic [SRAM_ADDR_W-1:0] in_left_q;
  logic [SRAM_ADDR_W-1:0] out_left_q;
  logic [SRAM_ADDR_W-1:0] addr_q;
  logic                   done_q;
  logic                   overflow_q;
  logic [SRAM_DATA_W-1:0] fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   start_acc;
  logic                   start_nil;
  logic                   smp_acc;
  logic                   wr_hs;
  logic                   last_byte;
  logic                   last_word;

  assign start_acc = (state_q == IDLE) && start && (word_count != '0);
  assign start_nil = (state_q == IDLE) && start && (word_count == '0);
  // A byte that completes a word needs a free FIFO slot; earlier bytes only fill the packer.
  assign smp_ready = (state_q == RUN) && (!fifo_full || (byte_cnt_q != 2'd3));
  assign smp_acc   = smp_valid && smp_ready;
  assign wr_valid  = !fifo_empty;
  assign wr_hs     = wr_valid && wr_ready;
  assign last_byte = smp_acc && (byte_cnt_q == 2'd3) && (in_left_q == SRAM_ADDR_W'(1));
  assign last_word = (state_q == DRAIN) && wr_hs && (out_left_q == SRAM_ADDR_W'(1));
  assign wr_addr   = addr_q;
  assign wr_data   = wr_valid ? fifo_head : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign overflow  = overflow_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = RUN;
      RUN:     if (last_byte) state_d = DRAIN;
      DRAIN:   if (last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte packer: assemble a word, then hand it to the FIFO one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      pack_q     <= '0;
      word_q     <= '0;
      push_q     <= 1'b0;
      in_left_q  <= '0;
    end else begin
      push_q <= 1'b0;
      if (start_acc) begin
        byte_cnt_q <= '0;
        in_left_q  <= word_count;
      end else if (smp_acc) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        case (byte_cnt_q)
          2'd0:    pack_q[7:0]   <= smp_data;
          2'd1:    pack_q[15:8]  <= smp_data;
          2'd2:    pack_q[23:16] <= smp_data;
          default: begin
            word_q    <= {smp_data, pack_q};
            push_q    <= 1'b1;
            in_left_q <= in_left_q - SRAM_ADDR_W'(1);
          end
        endcase
      end
    end
  end

  // Write-side address and remaining-word counter; address wraps at 2^18.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      out_left_q <= '0;
    end else if (start_acc) begin
      addr_q     <= base_addr;
      out_left_q <= word_count;
    end else if (wr_hs) begin
      addr_q     <= addr_q + SRAM_ADDR_W'(1);
      out_left_q <= out_left_q - SRAM_ADDR_W'(1);
    end
  end

  // Completion pulse and sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= start_nil || last_word;
      if (start_acc)
        overflow_q <= 1'b0;
      else if ((state_q == RUN) && smp_valid && !smp_ready)
        overflow_q <= 1'b1;
    end
  end

  sram_wr_fifo #(
    .WIDTH (SRAM_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_q),
    .wr_data (word_q),
    .pop     (wr_hs),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_sram_wr_sequencer.sv
// Bench for sram_wr_sequencer: directed captures, a per-cycle behavioural
// model of the capture (byte/word counts and a queue of buffered words),
// and literal expectations for each scenario.
module tb_sram_wr_sequencer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [17:0] base_addr = '0;
  logic [17:0] word_count = '0;
  logic        smp_valid = 1'b0;
  logic        smp_ready;
  logic [7:0]  smp_data = '0;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic [17:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        overflow;

  always #5 clk = ~clk;

  sram_wr_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .smp_valid  (smp_valid),
    .smp_ready  (smp_ready),
    .smp_data   (smp_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model of the capture
  bit          m_busy = 0;
  bit          m_done = 0;
  bit          m_ovf = 0;
  bit          m_pend = 0;
  logic [17:0] m_base = '0;
  int          m_wc = 0;
  int          m_bytes = 0;
  int          m_written = 0;
  logic [31:0] m_acc = '0;
  logic [31:0] m_pend_word = '0;
  logic [31:0] m_q[$];

  logic [49:0] wlog[$];
  int done_cnt = 0;
  int valid_cnt = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin : compare
    bit e_ready, e_valid, acc, hs, was_busy, nd;
    logic [17:0] e_addr;
    if (rst) begin
      chk("rst_smp_ready", smp_ready, 0);
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      m_busy = 0; m_done = 0; m_ovf = 0; m_pend = 0;
      m_bytes = 0; m_written = 0; m_wc = 0;
      m_q.delete();
    end else begin
      e_valid = (m_q.size() > 0);
      e_ready = m_busy && (m_bytes < 4 * m_wc) &&
                !(((m_bytes % 4) == 3) && (m_q.size() >= DEPTH));
      e_addr  = m_base + 18'(m_written);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("overflow", overflow, m_ovf);
      chk("smp_ready", smp_ready, e_ready);
      chk("wr_valid", wr_valid, e_valid);
      if (e_valid) begin
        chk("wr_addr", wr_addr, e_addr);
        chk("wr_data", wr_data, m_q[0]);
      end
      if (done)     done_cnt++;
      if (wr_valid) valid_cnt++;
      if (busy)     busy_cnt++;

      acc = smp_valid && e_ready;
      hs = e_valid && wr_ready;
      was_busy = m_busy;
      nd = 0;
      if (hs) wlog.push_back({wr_addr, wr_data});
      if (m_busy && (m_bytes < 4 * m_wc) && smp_valid && !e_ready) m_ovf = 1;
      if (m_pend) begin
        m_q.push_back(m_pend_word);
        m_pend = 0;
      end
      if (acc) begin
        m_acc[8 * (m_bytes % 4) +: 8] = smp_data;
        if ((m_bytes % 4) == 3) begin
          m_pend_word = m_acc;
          m_pend = 1;
        end
        m_bytes++;
      end
      if (hs) begin
        void'(m_q.pop_front());
        m_written++;
        if (m_written == m_wc) begin
          m_busy = 0;
          nd = 1;
        end
      end
      if (start && !was_busy) begin
        if (word_count != 0) begin
          m_busy = 1; m_base = base_addr; m_wc = int'(word_count);
          m_bytes = 0; m_written = 0; m_ovf = 0; m_pend = 0;
          m_q.delete();
        end else begin
          nd = 1;
        end
      end
      m_done = nd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [17:0] b, input logic [17:0] wc);
    base_addr = b;
    word_count = wc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] first, input int n);
    int got = 0;
    int cyc = 0;
    bit a;
    smp_valid = 1'b1;
    smp_data = first;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      a = smp_ready;
      tick();
      cyc++;
      if (a) begin
        got++;
        smp_data = first + 8'(got);
      end
    end
    smp_valid = 1'b0;
    chk("bytes_sent", got, n);
  endtask

  task automatic wait_idle(input int budget);
    int cyc = 0;
    while (busy && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("idle_reached", busy, 0);
    tick();
    tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int d0, v0, b0, got;
    bit a;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // basic two-word capture
    wr_ready = 1'b1;
    wlog.delete();
    d0 = done_cnt;
    do_start(18'h00010, 18'd2);
    send_bytes(8'h01, 8);
    wait_idle(50);
    chk("t1_nwr", wlog.size(), 2);
    chk("t1_w0", wlog[0], {18'h00010, 32'h04030201});
    chk("t1_w1", wlog[1], {18'h00011, 32'h08070605});
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_busy", busy, 0);

    // address wrap
    wlog.delete();
    do_start(18'h3FFFF, 18'd2);
    send_bytes(8'h11, 8);
    wait_idle(50);
    chk("t2_nwr", wlog.size(), 2);
    chk("t2_w0", wlog[0], {18'h3FFFF, 32'h14131211});
    chk("t2_w1", wlog[1], {18'h00000, 32'h18171615});

    // downstream stall with continuous upstream data
    wr_ready = 1'b0;
    wlog.delete();
    do_start(18'h00100, 18'd3);
    got = 0;
    smp_valid = 1'b1;
    smp_data = 8'h21;
    for (int c = 0; c < 300 && got < 12; c++) begin
      if (c == 40) begin
        chk("t3_overflow", overflow, 1);
        chk("t3_smp_ready", smp_ready, 0);
        chk("t3_wr_valid", wr_valid, 1);
        chk("t3_wr_addr", wr_addr, 18'h00100);
        chk("t3_wr_data", wr_data, 32'h24232221);
        chk("t3_bytes_at_stall", got, 11);
        wr_ready = 1'b1;
      end
      @(negedge clk);
      a = smp_ready;
      tick();
      if (a) begin
        got++;
        smp_data = 8'h21 + 8'(got);
      end
    end
    smp_valid = 1'b0;
    chk("t3_bytes", got, 12);
    wait_idle(50);
    chk("t3_nwr", wlog.size(), 3);
    chk("t3_w2", wlog[2], {18'h00102, 32'h2C2B2A29});

    // zero-length request
    d0 = done_cnt; b0 = busy_cnt; v0 = valid_cnt;
    do_start(18'h00500, 18'd0);
    chk("t4_done_now", done, 1);
    tick();
    chk("t4_done_after", done, 0);
    tick();
    chk("t4_done_cnt", done_cnt - d0, 1);
    chk("t4_busy_cnt", busy_cnt - b0, 0);
    chk("t4_valid_cnt", valid_cnt - v0, 0);

    // reset mid-capture
    wr_ready = 1'b0;
    do_start(18'h00040, 18'd4);
    send_bytes(8'h31, 5);
    chk("t5_valid_pre", wr_valid, 1);
    rst = 1'b1;
    #1;
    chk("t5_smp_ready", smp_ready, 0);
    chk("t5_wr_valid", wr_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_wr_addr", wr_addr, 0);
    chk("t5_wr_data", wr_data, 0);
    tick();
    tick();
    rst = 1'b0;
    wr_ready = 1'b1;
    v0 = valid_cnt; d0 = done_cnt;
    repeat (10) tick();
    chk("t5_no_wr", valid_cnt - v0, 0);
    chk("t5_no_done", done_cnt - d0, 0);
    wlog.delete();
    do_start(18'h00200, 18'd1);
    send_bytes(8'h51, 4);
    wait_idle(50);
    chk("t5_nwr", wlog.size(), 1);
    chk("t5_w0", wlog[0], {18'h00200, 32'h54535251});

    // start during RUN is ignored
    wlog.delete();
    do_start(18'h00300, 18'd2);
    send_bytes(8'h61, 2);
    do_start(18'h003A0, 18'd5);
    send_bytes(8'h63, 6);
    wait_idle(50);
    chk("t6_nwr", wlog.size(), 2);
    chk("t6_w0", wlog[0], {18'h00300, 32'h64636261});
    chk("t6_w1", wlog[1], {18'h00301, 32'h68676665});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
